// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: rebuilds the pixel position from an hsync/vsync pair,
// measures the incoming timing and reports lock once consecutive frames agree.
module vga_sync_receiver #(
    parameter int ACTIVE_LOW  = 1,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hsync_in,
    input  logic        i_vsync_in,
    output logic [10:0] o_x,
    output logic [9:0]  o_y,
    output logic        o_display_on,
    output logic        o_locked,
    output logic [10:0] o_line_len,
    output logic [9:0]  o_frame_lines,
    output logic [10:0] o_hsync_width,
    output logic [9:0]  o_vsync_width,
    output logic        o_frame_strobe
);
    localparam logic [1:0]  ST_SEARCH = 2'd0;
    localparam logic [1:0]  ST_TRACK  = 2'd1;
    localparam logic [1:0]  ST_LOCKED = 2'd2;
    localparam logic        ACT_LVL   = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic        IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [10:0] H_LO      = 11'(H_START);
    localparam logic [10:0] H_HI      = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO      = 10'(V_START);
    localparam logic [9:0]  V_HI      = 10'(V_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
    localparam logic [10:0] H_MAX     = 11'h7FF;
    localparam logic [9:0]  V_MAX     = 10'h3FF;

    logic [1:0]  r_hs_sync, r_vs_sync;
    logic        r_hs_prev, r_vs_prev;
    logic [10:0] r_hcnt, r_line_len, r_hsync_width, r_ref_ll, r_x;
    logic [9:0]  r_vcnt, r_frame_lines, r_vsync_width, r_ref_fl, r_y;
    logic [1:0]  r_state;
    logic [3:0]  r_lock_cnt;
    logic        r_locked, r_display_on, r_frame_strobe;

    logic        w_hs_act, w_vs_act, w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [10:0] w_hcnt_inc, w_ll_cur;
    logic [9:0]  w_vcnt_inc;
    logic [3:0]  w_lock_cnt_inc, w_lock_cnt_nxt;
    logic [1:0]  w_state_nxt;
    logic        w_timeout, w_match, w_in_win;

    assign w_hs_act       = (r_hs_sync[1] == ACT_LVL);
    assign w_vs_act       = (r_vs_sync[1] == ACT_LVL);
    assign w_hs_rise      = w_hs_act & ~r_hs_prev;
    assign w_hs_fall      = ~w_hs_act & r_hs_prev;
    assign w_vs_rise      = w_vs_act & ~r_vs_prev;
    assign w_vs_fall      = ~w_vs_act & r_vs_prev;
    assign w_hcnt_inc     = (r_hcnt == H_MAX) ? H_MAX : (r_hcnt + 11'd1);
    assign w_vcnt_inc     = (r_vcnt == V_MAX) ? V_MAX : (r_vcnt + 10'd1);
    assign w_timeout      = (r_hcnt == H_MAX);
    assign w_lock_cnt_inc = r_lock_cnt + 4'd1;
    // A line ending in the same clock as the vsync edge must count as this frame's line length.
    assign w_ll_cur       = w_hs_rise ? w_hcnt_inc : r_line_len;
    assign w_match        = (w_ll_cur == r_ref_ll) && (w_vcnt_inc == r_ref_fl) &&
                            (w_ll_cur != 11'd0) && (w_vcnt_inc != 10'd0);
    assign w_in_win       = (r_state == ST_LOCKED) &&
                            (r_hcnt >= H_LO) && (r_hcnt < H_HI) &&
                            (r_vcnt >= V_LO) && (r_vcnt < V_HI);

    // Pin synchronizers and the previous normalised level used for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hs_sync <= {2{IDLE_LVL}};
            r_vs_sync <= {2{IDLE_LVL}};
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_hs_sync <= {r_hs_sync[0], i_hsync_in};
            r_vs_sync <= {r_vs_sync[0], i_vsync_in};
            r_hs_prev <= w_hs_act;
            r_vs_prev <= w_vs_act;
        end
    end

    // Position counters and timing measurements
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt         <= 11'd0;
            r_vcnt         <= 10'd0;
            r_line_len     <= 11'd0;
            r_hsync_width  <= 11'd0;
            r_frame_lines  <= 10'd0;
            r_vsync_width  <= 10'd0;
            r_frame_strobe <= 1'b0;
        end else begin
            r_hcnt         <= w_hs_rise ? 11'd0 : w_hcnt_inc;
            r_frame_strobe <= w_vs_rise;
            if (w_vs_rise) begin
                r_vcnt <= 10'd0;
            end else if (w_hs_rise) begin
                r_vcnt <= w_vcnt_inc;
            end else begin
                r_vcnt <= r_vcnt;
            end
            if (w_hs_rise) r_line_len <= w_hcnt_inc;
            if (w_hs_fall) r_hsync_width <= w_hcnt_inc;
            if (w_vs_rise) r_frame_lines <= w_vcnt_inc;
            if (w_vs_fall) r_vsync_width <= w_vcnt_inc;
        end
    end

    // Lock state machine: next state and consecutive-match count
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_rise) begin
                    w_state_nxt    = ST_TRACK;
                    w_lock_cnt_nxt = 4'd0;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (w_timeout) begin
                    w_state_nxt    = ST_SEARCH;
                    w_lock_cnt_nxt = 4'd0;
                end else if (w_vs_rise && w_match) begin
                    w_lock_cnt_nxt = w_lock_cnt_inc;
                    if (w_lock_cnt_inc == LOCK_N) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_TRACK;
                    end
                end else if (w_vs_rise) begin
                    w_lock_cnt_nxt = 4'd0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt;
                end
            end
            ST_LOCKED: begin
                if (w_timeout || (w_vs_rise && !w_match)) begin
                    w_state_nxt    = ST_SEARCH;
                    w_lock_cnt_nxt = 4'd0;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt    = ST_SEARCH;
                w_lock_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Lock state registers and the previous frame's reference measurements
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_SEARCH;
            r_lock_cnt <= 4'd0;
            r_locked   <= 1'b0;
            r_ref_ll   <= 11'd0;
            r_ref_fl   <= 10'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            if (w_vs_rise) begin
                r_ref_ll <= w_ll_cur;
                r_ref_fl <= w_vcnt_inc;
            end
        end
    end

    // Display window and recovered coordinates, one clock behind the counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_display_on <= 1'b0;
            r_x          <= 11'd0;
            r_y          <= 10'd0;
        end else begin
            r_display_on <= w_in_win;
            r_x          <= w_in_win ? (r_hcnt - H_LO) : 11'd0;
            r_y          <= w_in_win ? (r_vcnt - V_LO) : 10'd0;
        end
    end

    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_display_on   = r_display_on;
    assign o_locked       = r_locked;
    assign o_line_len     = r_line_len;
    assign o_frame_lines  = r_frame_lines;
    assign o_hsync_width  = r_hsync_width;
    assign o_vsync_width  = r_vsync_width;
    assign o_frame_strobe = r_frame_strobe;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: an active-low and an active-high instance watch the same
// stream (80 clocks x 20 lines, hsync 8 clocks, vsync 2 lines, edges coincident at line start).
`timescale 1ns/1ps
module tb_vga_sync_receiver;
    localparam int HST = 20, HAC = 48, VST = 3, VAC = 14;
    localparam int H_TOT = 80, H_SW = 8, V_SW = 2;

    logic clk = 1'b0, rst = 1'b1, hs = 1'b1, vs = 1'b1;
    logic hs_n, vs_n;
    logic [10:0] l_x, h_x, l_ll, h_ll, l_hw, h_hw;
    logic [9:0]  l_y, h_y, l_fl, h_fl, l_vw, h_vw;
    logic        l_de, h_de, l_lk, h_lk, l_fs, h_fs;
    int n_tests = 0, n_fail = 0, cyc = 0;

    typedef struct { int due; int col; int row; logic de; logic [10:0] x; logic [9:0] y; } exp_t;
    exp_t sb[$];
    // row, col, display_on, x, y of the probed pixels
    int probes [9][5] = '{'{10, 19, 0, 0, 0}, '{10, 20, 1, 0, 7}, '{10, 25, 1, 5, 7},
                          '{10, 67, 1, 47, 7}, '{10, 68, 0, 0, 0}, '{2, 25, 0, 0, 0},
                          '{3, 20, 1, 0, 0}, '{16, 67, 1, 47, 13}, '{17, 67, 0, 0, 0}};

    assign hs_n = ~hs;
    assign vs_n = ~vs;
    always #5 clk = ~clk;

    vga_sync_receiver #(.ACTIVE_LOW(1), .H_START(HST), .H_ACTIVE(HAC), .V_START(VST),
                        .V_ACTIVE(VAC), .LOCK_FRAMES(3)) u_lo (
        .i_clk(clk), .i_rst(rst), .i_hsync_in(hs), .i_vsync_in(vs),
        .o_x(l_x), .o_y(l_y), .o_display_on(l_de), .o_locked(l_lk), .o_line_len(l_ll),
        .o_frame_lines(l_fl), .o_hsync_width(l_hw), .o_vsync_width(l_vw), .o_frame_strobe(l_fs));

    vga_sync_receiver #(.ACTIVE_LOW(0), .H_START(HST), .H_ACTIVE(HAC), .V_START(VST),
                        .V_ACTIVE(VAC), .LOCK_FRAMES(3)) u_hi (
        .i_clk(clk), .i_rst(rst), .i_hsync_in(hs_n), .i_vsync_in(vs_n),
        .o_x(h_x), .o_y(h_y), .o_display_on(h_de), .o_locked(h_lk), .o_line_len(h_ll),
        .o_frame_lines(h_fl), .o_hsync_width(h_hw), .o_vsync_width(h_vw), .o_frame_strobe(h_fs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [31:0] ol, input logic [31:0] oh,
                        input logic [31:0] exp);
        chk({"lo.", tag}, ol, exp);
        chk({"hi.", tag}, oh, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk2({tag, ".x"}, l_x, h_x, 0);
        chk2({tag, ".y"}, l_y, h_y, 0);
        chk2({tag, ".display_on"}, l_de, h_de, 0);
        chk2({tag, ".locked"}, l_lk, h_lk, 0);
        chk2({tag, ".line_len"}, l_ll, h_ll, 0);
        chk2({tag, ".frame_lines"}, l_fl, h_fl, 0);
        chk2({tag, ".hsync_width"}, l_hw, h_hw, 0);
        chk2({tag, ".vsync_width"}, l_vw, h_vw, 0);
        chk2({tag, ".frame_strobe"}, l_fs, h_fs, 0);
    endtask

    // One clock: retire due scoreboard entries, then drive the pins for this position.
    task automatic step(input logic hs_v, input logic vs_v);
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk2($sformatf("de(r%0d,c%0d)", e.row, e.col), l_de, h_de, e.de);
            chk2($sformatf("x(r%0d,c%0d)", e.row, e.col), l_x, h_x, e.x);
            chk2($sformatf("y(r%0d,c%0d)", e.row, e.col), l_y, h_y, e.y);
        end
        hs = hs_v;
        vs = vs_v;
    endtask

    task automatic run_frame(input int nlines, input int first, input bit vs_en,
                             input logic lk_before, input logic lk_after,
                             input int exp_fl, input bit probe, input int rst_line);
        for (int l = first; l < nlines; l++) begin
            for (int c = 0; c < H_TOT; c++) begin
                step((c < H_SW) ? 1'b0 : 1'b1, (vs_en && l < V_SW) ? 1'b0 : 1'b1);
                if (probe) begin
                    for (int k = 0; k < 9; k++) begin
                        if (probes[k][0] == l && probes[k][1] == c) begin
                            exp_t e;
                            e.due = cyc + 4; e.col = c; e.row = l;
                            e.de = (probes[k][2] != 0);
                            e.x = 11'(probes[k][3]);
                            e.y = 10'(probes[k][4]);
                            sb.push_back(e);
                        end
                    end
                end
                if (vs_en && l == 0 && c == 2) begin
                    chk2("locked_pre_edge", l_lk, h_lk, lk_before);
                    chk2("strobe_pre", l_fs, h_fs, 0);
                end
                if (vs_en && l == 0 && c == 3) begin
                    chk2("locked_post_edge", l_lk, h_lk, lk_after);
                    chk2("strobe", l_fs, h_fs, 1);
                end
                if (vs_en && l == 0 && c == 4) chk2("strobe_post", l_fs, h_fs, 0);
                if (l == 5 && c == 40) begin
                    chk2("line_len", l_ll, h_ll, 80);
                    chk2("hsync_width", l_hw, h_hw, H_SW);
                    chk2("frame_lines", l_fl, h_fl, exp_fl);
                    chk2("vsync_width", l_vw, h_vw, vs_en ? V_SW : 0);
                    chk2("locked_mid", l_lk, h_lk, lk_after);
                end
                if (l == rst_line && c == 10) rst = 1'b1;
                if (l == rst_line && c == 11) begin
                    chk_zero("midframe_rst");
                    rst = 1'b0;
                end
            end
        end
    endtask

    initial begin
        repeat (4) step(1'b1, 1'b1);
        chk_zero("reset");
        rst = 1'b0;
        repeat (5) step(1'b1, 1'b1);
        // First frame starts at line 1 so the first vsync edge closes a complete frame.
        run_frame(20, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b1, 20, 1'b1, -1);
        run_frame(19, 0, 1'b1, 1'b1, 1'b1, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b1, 1'b0, 19, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b1, 20, 1'b0, -1);
        // hcnt reaches 2047 at idle clock 1970 and lock drops on the following clock.
        for (int i = 0; i < 2100; i++) begin
            step(1'b1, 1'b1);
            if (i == 1970) chk2("locked_before_timeout", l_lk, h_lk, 1);
            if (i == 1971) chk2("locked_after_timeout", l_lk, h_lk, 0);
        end
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, 8);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 12, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1);
        run_frame(20, 0, 1'b1, 1'b0, 1'b1, 20, 1'b1, -1);
        repeat (6) step(1'b1, 1'b1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
